// File: rtl/glb_netwk_pattern_gen_if.sv
// Configuration write port of the global-network pattern generator.
// valid/ready: a write transfers on any clk edge where cfg_valid && cfg_ready.
interface glb_netwk_pattern_gen_if #(
   parameter int DIV_W = 8
) ();
   logic             cfg_valid;
   logic             cfg_ready;
   logic [2:0]       cfg_sel;
   logic [DIV_W-1:0] cfg_div;

   modport master (output cfg_valid, output cfg_sel, output cfg_div, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_sel, input cfg_div, output cfg_ready);
endinterface

// File: rtl/glb_netwk_pattern_gen.sv
// Fabric-driven square-wave generator feeding global-buffer user-signal inputs.
// Each channel toggles every div cycles; a two-state write FSM loads dividers.
module glb_netwk_pattern_gen #(
   parameter int CHANNELS = 8,
   parameter int DIV_W    = 8
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    run_i,
   glb_netwk_pattern_gen_if.slave  cfg,
   output logic [CHANNELS-1:0]     glb_drv_o,
   output logic                    phase_sync_o,
   output logic                    par_o,
   output logic                    wr_state_o
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_COMMIT = 1'b1
   } wr_state_e;

   wr_state_e state_q, state_d;

   logic [DIV_W-1:0]    div_q [CHANNELS];
   logic [DIV_W-1:0]    div_d [CHANNELS];
   logic [DIV_W-1:0]    cnt_q [CHANNELS];
   logic [DIV_W-1:0]    cnt_d [CHANNELS];
   logic [CHANNELS-1:0] drv_q, drv_d;
   logic                par_q;

   logic wr_ready;
   logic wr_accept;
   logic any_en;
   logic all_origin;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         for (int i = 0; i < CHANNELS; i++) begin
            div_q[i] <= '0;
            cnt_q[i] <= '0;
         end
         drv_q <= '0;
         par_q <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         drv_q   <= drv_d;
         par_q   <= ^drv_q;
      end
   end

   // COMMIT is a mandatory dead cycle after every accepted write.
   always_comb begin
      state_d  = state_q;
      wr_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            wr_ready = 1'b1;
            if (cfg.cfg_valid) state_d = ST_COMMIT;
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   assign wr_accept     = cfg.cfg_valid && wr_ready;
   assign cfg.cfg_ready = wr_ready;

   // A write to a channel wins over its advance; out-of-range selects match nothing.
   always_comb begin
      div_d      = div_q;
      cnt_d      = cnt_q;
      drv_d      = drv_q;
      any_en     = 1'b0;
      all_origin = 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
         if (div_q[i] != '0) begin
            any_en = 1'b1;
            if (cnt_q[i] != '0 || drv_q[i]) all_origin = 1'b0;
         end
         if (wr_accept && cfg.cfg_sel == 3'(i)) begin
            div_d[i] = cfg.cfg_div;
            cnt_d[i] = '0;
            drv_d[i] = 1'b0;
         end else if (run_i && div_q[i] != '0) begin
            if (cnt_q[i] == div_q[i] - DIV_W'(1)) begin
               cnt_d[i] = '0;
               drv_d[i] = ~drv_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
         end
      end
   end

   assign glb_drv_o    = drv_q;
   assign par_o        = par_q;
   assign phase_sync_o = run_i & any_en & all_origin;
   assign wr_state_o   = state_q;

endmodule

// File: tb/tb_glb_netwk_pattern_gen.sv
// Directed bench for glb_netwk_pattern_gen: one task per scenario, inline checks.
module tb_glb_netwk_pattern_gen;

   logic       clk;
   logic       resetn;
   logic       run;
   logic [7:0] glb_drv;
   logic       phase_sync;
   logic       par;
   logic       wr_state;

   int n_cmp  = 0;
   int n_fail = 0;

   glb_netwk_pattern_gen_if #(.DIV_W(8)) cfg_if ();

   glb_netwk_pattern_gen #(.CHANNELS(8), .DIV_W(8)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .run_i        (run),
      .cfg          (cfg_if),
      .glb_drv_o    (glb_drv),
      .phase_sync_o (phase_sync),
      .par_o        (par),
      .wr_state_o   (wr_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // drivers: inputs change and outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn           = 1'b0;
      run              = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_sel   = 3'd0;
      cfg_if.cfg_div   = 8'd0;
      step();
      step();
      resetn = 1'b1;
   endtask

   // two edges: accept edge then COMMIT edge
   task automatic write_cfg(input logic [2:0] sel, input logic [7:0] dv);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_sel   = sel;
      cfg_if.cfg_div   = dv;
      step();
      cfg_if.cfg_valid = 1'b0;
      step();
   endtask

   task automatic test_reset();
      resetn           = 1'b0;
      run              = 1'b1;
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_sel   = 3'd0;
      cfg_if.cfg_div   = 8'd5;
      for (int c = 0; c < 3; c++) step();
      n_cmp++; if (glb_drv !== 8'h00) begin n_fail++; $display("FAIL reset_glb_drv: got %h expected %h", glb_drv, 8'h00); end
      n_cmp++; if (par !== 1'b0) begin n_fail++; $display("FAIL reset_par: got %b expected %b", par, 1'b0); end
      n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b expected %b", cfg_if.cfg_ready, 1'b1); end
      n_cmp++; if (phase_sync !== 1'b0) begin n_fail++; $display("FAIL reset_phase_sync: got %b expected %b", phase_sync, 1'b0); end
      n_cmp++; if (wr_state !== 1'b0) begin n_fail++; $display("FAIL reset_wr_state: got %b expected %b", wr_state, 1'b0); end
      resetn = 1'b1;
      step();
      n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_first_accept_ready: got %b expected %b", cfg_if.cfg_ready, 1'b0); end
      n_cmp++; if (wr_state !== 1'b1) begin n_fail++; $display("FAIL reset_first_accept_state: got %b expected %b", wr_state, 1'b1); end
      cfg_if.cfg_valid = 1'b0;
      step();
      n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_back_to_idle: got %b expected %b", cfg_if.cfg_ready, 1'b1); end
   endtask

   task automatic test_clk_div2();
      logic [7:0] exp_drv;
      logic       exp_par;
      logic       exp_sync;
      do_reset();
      write_cfg(3'd0, 8'd1);
      run = 1'b1;
      #1;
      n_cmp++; if (glb_drv !== 8'h00) begin n_fail++; $display("FAIL div2_start: got %h expected %h", glb_drv, 8'h00); end
      n_cmp++; if (phase_sync !== 1'b1) begin n_fail++; $display("FAIL div2_sync_start: got %b expected %b", phase_sync, 1'b1); end
      for (int j = 1; j <= 8; j++) begin
         step();
         exp_drv  = {7'd0, 1'(j % 2)};
         exp_par  = 1'((j - 1) % 2);
         exp_sync = (j % 2 == 0);
         n_cmp++; if (glb_drv !== exp_drv) begin n_fail++; $display("FAIL div2_drv[%0d]: got %h expected %h", j, glb_drv, exp_drv); end
         n_cmp++; if (par !== exp_par) begin n_fail++; $display("FAIL div2_par[%0d]: got %b expected %b", j, par, exp_par); end
         n_cmp++; if (phase_sync !== exp_sync) begin n_fail++; $display("FAIL div2_sync[%0d]: got %b expected %b", j, phase_sync, exp_sync); end
      end
   endtask

   task automatic test_slow_channel();
      logic [7:0] exp_drv;
      do_reset();
      write_cfg(3'd3, 8'd3);
      run = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         step();
         exp_drv = {4'd0, 1'((j / 3) % 2), 3'd0};
         n_cmp++; if (glb_drv !== exp_drv) begin n_fail++; $display("FAIL slow_drv[%0d]: got %h expected %h", j, glb_drv, exp_drv); end
      end
   endtask

   task automatic test_back_to_back();
      logic       exp_rdy;
      logic [7:0] exp_drv;
      do_reset();
      cfg_if.cfg_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cfg_if.cfg_sel = 3'(c);
         cfg_if.cfg_div = 8'(c + 1);
         #1;
         exp_rdy = (c % 2 == 0);
         n_cmp++; if (cfg_if.cfg_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected %b", c, cfg_if.cfg_ready, exp_rdy); end
         step();
      end
      cfg_if.cfg_valid = 1'b0;
      // ch0 (div 1) and ch2 (div 3) must run; ch1 and ch3 never written
      run = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         step();
         exp_drv = {5'd0, 1'((j / 3) % 2), 1'b0, 1'(j % 2)};
         n_cmp++; if (glb_drv !== exp_drv) begin n_fail++; $display("FAIL b2b_drv[%0d]: got %h expected %h", j, glb_drv, exp_drv); end
      end
   endtask

   task automatic test_run_hold();
      do_reset();
      write_cfg(3'd1, 8'd4);
      run = 1'b1;
      step();
      step();
      run = 1'b0;
      #1;
      n_cmp++; if (phase_sync !== 1'b0) begin n_fail++; $display("FAIL hold_sync_off: got %b expected %b", phase_sync, 1'b0); end
      for (int j = 1; j <= 5; j++) begin
         step();
         n_cmp++; if (glb_drv !== 8'h00) begin n_fail++; $display("FAIL hold_frozen[%0d]: got %h expected %h", j, glb_drv, 8'h00); end
      end
      run = 1'b1;
      step();
      n_cmp++; if (glb_drv !== 8'h00) begin n_fail++; $display("FAIL hold_resume1: got %h expected %h", glb_drv, 8'h00); end
      step();
      n_cmp++; if (glb_drv !== 8'h02) begin n_fail++; $display("FAIL hold_resume2: got %h expected %h", glb_drv, 8'h02); end
      step();
      step();
      // cnt=2, drv=1: rewrite restarts from (0,0); commit edge advances to cnt=1
      write_cfg(3'd1, 8'd4);
      n_cmp++; if (glb_drv !== 8'h00) begin n_fail++; $display("FAIL hold_restart: got %h expected %h", glb_drv, 8'h00); end
      step();
      step();
      n_cmp++; if (glb_drv !== 8'h00) begin n_fail++; $display("FAIL hold_restart_cnt3: got %h expected %h", glb_drv, 8'h00); end
      step();
      n_cmp++; if (glb_drv !== 8'h02) begin n_fail++; $display("FAIL hold_restart_toggle: got %h expected %h", glb_drv, 8'h02); end
   endtask

   task automatic test_sync();
      logic exp_sync;
      do_reset();
      write_cfg(3'd0, 8'd1);
      write_cfg(3'd1, 8'd2);
      n_cmp++; if (phase_sync !== 1'b0) begin n_fail++; $display("FAIL sync_run_low: got %b expected %b", phase_sync, 1'b0); end
      run = 1'b1;
      #1;
      n_cmp++; if (phase_sync !== 1'b1) begin n_fail++; $display("FAIL sync_cycle0: got %b expected %b", phase_sync, 1'b1); end
      for (int j = 1; j <= 8; j++) begin
         step();
         exp_sync = (j % 4 == 0);
         n_cmp++; if (phase_sync !== exp_sync) begin n_fail++; $display("FAIL sync_p4[%0d]: got %b expected %b", j, phase_sync, exp_sync); end
      end
      write_cfg(3'd1, 8'd0);
      n_cmp++; if (phase_sync !== 1'b1) begin n_fail++; $display("FAIL sync_after_disable: got %b expected %b", phase_sync, 1'b1); end
      for (int k = 1; k <= 4; k++) begin
         step();
         exp_sync = (k % 2 == 0);
         n_cmp++; if (phase_sync !== exp_sync) begin n_fail++; $display("FAIL sync_p2[%0d]: got %b expected %b", k, phase_sync, exp_sync); end
         n_cmp++; if (glb_drv[1] !== 1'b0) begin n_fail++; $display("FAIL sync_disabled_drv[%0d]: got %b expected %b", k, glb_drv[1], 1'b0); end
      end
   endtask

   task automatic test_max_div();
      do_reset();
      write_cfg(3'd5, 8'd255);
      run = 1'b1;
      for (int j = 1; j <= 254; j++) step();
      n_cmp++; if (glb_drv !== 8'h00) begin n_fail++; $display("FAIL max_before_toggle: got %h expected %h", glb_drv, 8'h00); end
      step();
      n_cmp++; if (glb_drv !== 8'h20) begin n_fail++; $display("FAIL max_first_toggle: got %h expected %h", glb_drv, 8'h20); end
      for (int j = 1; j <= 254; j++) step();
      n_cmp++; if (glb_drv !== 8'h20) begin n_fail++; $display("FAIL max_high_hold: got %h expected %h", glb_drv, 8'h20); end
      step();
      n_cmp++; if (glb_drv !== 8'h00) begin n_fail++; $display("FAIL max_second_toggle: got %h expected %h", glb_drv, 8'h00); end
   endtask

   initial begin
      resetn           = 1'b0;
      run              = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_sel   = 3'd0;
      cfg_if.cfg_div   = 8'd0;
      test_reset();
      test_clk_div2();
      test_slow_channel();
      test_back_to_back();
      test_run_hold();
      test_sync();
      test_max_div();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
